// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido control unit: FSM state encoding,
// instruction opcodes and field positions, ALU opcodes and the decoded-word type.
// Pure declarations with no logic, so no latency and no flow control here.
package lapido_pkg;

    localparam int INSTR_W = 32;

    // Instruction field positions: [31:24] op, [23:20] rd, [19:16] ra, [15:12] rb, [11:0] imm12
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 24;
    localparam int RD_MSB  = 23;
    localparam int RD_LSB  = 20;
    localparam int RA_MSB  = 19;
    localparam int RA_LSB  = 16;
    localparam int RB_MSB  = 15;
    localparam int RB_LSB  = 12;
    localparam int IMM_MSB = 11;
    localparam int IMM_LSB = 0;

    // Instruction opcodes
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_JMP    = 8'h10;
    localparam logic [7:0] OP_BRF    = 8'h11;
    localparam logic [7:0] OP_ALU_LO = 8'h20;
    localparam logic [7:0] OP_ALU_HI = 8'h3F;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    // ALU opcodes shared with the ALU; ALU-class instructions pass op through unchanged
    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h20;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_JMP,
        CLS_BRF,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        op_class_t   cls;
        logic [7:0]  alu_op;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] imm;
        logic        b_sel_imm;
    } dec_t;

    function automatic op_class_t classify(input logic [7:0] op);
        op_class_t c;
        c = CLS_ILLEGAL;
        if (op >= OP_ALU_LO && op <= OP_ALU_HI) begin
            c = CLS_ALU;
        end else begin
            case (op)
                OP_NOP:   c = CLS_NOP;
                OP_LOAD:  c = CLS_LOAD;
                OP_STORE: c = CLS_STORE;
                OP_JMP:   c = CLS_JMP;
                OP_BRF:   c = CLS_BRF;
                OP_HALT:  c = CLS_HALT;
                default:  c = CLS_ILLEGAL;
            endcase
        end
        return c;
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/lapido_decoder.sv
// Instruction decoder: splits an instruction word into class, register fields,
// sign-extended immediate and the ALU opcode / B-mux select it implies.
// Purely combinational (zero latency); no flow control.
// Ports: ir (instruction word in), dec (decoded fields out).
module lapido_decoder
    import lapido_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output dec_t               dec
);

    logic [7:0] op;
    assign op = ir[OP_MSB:OP_LSB];

    always_comb begin
        dec           = '0;
        dec.cls       = classify(op);
        dec.rd        = ir[RD_MSB:RD_LSB];
        dec.ra        = ir[RA_MSB:RA_LSB];
        dec.rb        = ir[RB_MSB:RB_LSB];
        dec.imm       = sext12(ir[IMM_MSB:IMM_LSB]);
        dec.alu_op    = ALU_NOP;
        dec.b_sel_imm = 1'b0;
        case (dec.cls)
            CLS_ALU: begin
                dec.alu_op = op;
            end
            // Memory ops use the ALU to form ra + imm
            CLS_LOAD, CLS_STORE: begin
                dec.alu_op    = ALU_ADD;
                dec.b_sel_imm = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lapido_control.sv
// Multi-cycle Lapido control unit: fetch, decode, execute, memory, writeback FSM plus PC.
// Latency with immediate mem_ready: ALU 4, LOAD 5, STORE 4, JMP/BRF/NOP 3 cycles.
// Backpressure: FETCH and MEM hold their strobes until mem_ready; mem_ready is ignored elsewhere.
// Ports: clock/reset; instr, mem_ready, alu_flag in; pc, memory strobes and address select,
// ALU opcode, register addresses, imm, B/writeback selects, reg_write, halted, illegal out.
module lapido_control
    import lapido_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic               alu_flag,
    output logic [31:0]        pc,
    output logic               mem_addr_sel,
    output logic               mem_read,
    output logic               mem_write,
    output logic [7:0]         alu_op,
    output logic [3:0]         rd,
    output logic [3:0]         ra,
    output logic [3:0]         rb,
    output logic [31:0]        imm,
    output logic               b_sel_imm,
    output logic               reg_write,
    output logic               wb_sel_mem,
    output logic               halted,
    output logic               illegal
);

    state_t              state;
    state_t              state_nxt;
    logic [INSTR_W-1:0]  ir;
    logic [INSTR_W-1:0]  dec_src;
    dec_t                dec;
    logic                fetch_done;

    // In FETCH the decoder looks at the incoming word so the registered ALU-side
    // fields can be loaded on the same edge that latches IR (DECODE entry).
    // In every later state it decodes the latched IR.
    assign dec_src    = (state == ST_FETCH) ? instr : ir;
    assign fetch_done = (state == ST_FETCH) && mem_ready;

    lapido_decoder u_decoder (
        .ir  (dec_src),
        .dec (dec)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        wb_sel_mem   = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        case (state)
            ST_FETCH: begin
                // Reset already holds the state in FETCH; gating keeps the
                // fetch strobe quiet until reset is actually released.
                mem_read = !reset;
                if (mem_ready) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                illegal = (dec.cls == CLS_ILLEGAL);
                case (dec.cls)
                    CLS_ALU:             state_nxt = ST_WB;
                    CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
                    CLS_HALT:            state_nxt = ST_HALT;
                    default:             state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_addr_sel = 1'b1;
                mem_read     = (dec.cls == CLS_LOAD);
                mem_write    = (dec.cls == CLS_STORE);
                if (mem_ready) begin
                    state_nxt = (dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel_mem = (dec.cls == CLS_LOAD);
                state_nxt  = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // IR, PC and the registered ALU-facing fields. The ALU fields change only on
    // DECODE entry so the ALU sees one opcode change per instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= PC_RESET;
            ir        <= '0;
            alu_op    <= ALU_NOP;
            rd        <= '0;
            ra        <= '0;
            rb        <= '0;
            imm       <= '0;
            b_sel_imm <= 1'b0;
        end else begin
            if (fetch_done) begin
                ir        <= instr;
                alu_op    <= dec.alu_op;
                rd        <= dec.rd;
                ra        <= dec.ra;
                rb        <= dec.rb;
                imm       <= dec.imm;
                b_sel_imm <= dec.b_sel_imm;
            end
            case (state)
                ST_EXEC: begin
                    case (dec.cls)
                        CLS_JMP:              pc <= pc + imm;
                        CLS_BRF:              pc <= alu_flag ? (pc + imm) : (pc + 32'd1);
                        CLS_NOP, CLS_ILLEGAL: pc <= pc + 32'd1;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready && dec.cls == CLS_STORE) begin
                        pc <= pc + 32'd1;
                    end
                end
                ST_WB: begin
                    pc <= pc + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lapido_control.sv
// Testbench for lapido_control: per-feature tasks with expectations queued per instruction.
// Each instruction runs from FETCH back to FETCH (or HALT) under a cycle budget.
// Outputs are sampled 1 time unit after the rising edge.
module tb_lapido_control;

    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_flag;
    logic [31:0] pc;
    logic        mem_addr_sel;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  alu_op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] imm;
    logic        b_sel_imm;
    logic        reg_write;
    logic        wb_sel_mem;
    logic        halted;
    logic        illegal;

    always #5 clock = ~clock;

    lapido_control #(.PC_RESET(PC_RST)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .alu_flag     (alu_flag),
        .pc           (pc),
        .mem_addr_sel (mem_addr_sel),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_op       (alu_op),
        .rd           (rd),
        .ra           (ra),
        .rb           (rb),
        .imm          (imm),
        .b_sel_imm    (b_sel_imm),
        .reg_write    (reg_write),
        .wb_sel_mem   (wb_sel_mem),
        .halted       (halted),
        .illegal      (illegal)
    );

    typedef struct {
        int          cycles;
        logic [31:0] pc;
        int          writes;
        int          wr_cycle;
        logic [3:0]  rd;
        logic        wb_mem;
        int          mem_rd;
        int          mem_wr;
        int          illegal_cnt;
        logic [7:0]  alu_op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] imm;
        logic        bsel;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rec_t blank_rec();
        rec_t r;
        r.cycles = -1; r.pc = '0; r.writes = 0; r.wr_cycle = 0; r.rd = '0;
        r.wb_mem = 1'b0; r.mem_rd = 0; r.mem_wr = 0; r.illegal_cnt = 0;
        r.alu_op = '0; r.ra = '0; r.rb = '0; r.imm = '0; r.bsel = 1'b0;
        return r;
    endfunction

    // Runs one instruction starting in a FETCH cycle. mem_cycles is how many MEM
    // cycles elapse before mem_ready is returned. alu_flag carries 'flag' only in
    // cycle 3 (EXEC) and its complement elsewhere.
    task automatic run_instr(input logic [31:0] word, input int mem_cycles,
                             input logic flag, output rec_t o);
        int mem_seen;
        mem_seen  = 0;
        o         = blank_rec();
        instr     = word;
        mem_ready = 1'b1;
        alu_flag  = !flag;
        for (int c = 2; c <= 60; c++) begin
            @(posedge clock); #1;
            if (c == 2) begin
                o.alu_op = alu_op; o.ra = ra; o.rb = rb; o.imm = imm; o.bsel = b_sel_imm;
            end
            if (reg_write) begin
                o.writes++; o.wr_cycle = c; o.rd = rd; o.wb_mem = wb_sel_mem;
            end
            if (mem_addr_sel && mem_read)  o.mem_rd++;
            if (mem_addr_sel && mem_write) o.mem_wr++;
            if (illegal) o.illegal_cnt++;
            if ((mem_read && !mem_addr_sel) || halted) begin
                o.cycles = c - 1;
                o.pc     = pc;
                break;
            end
            alu_flag = (c == 3) ? flag : !flag;
            if (mem_addr_sel) begin
                mem_seen++;
                mem_ready = (mem_seen >= mem_cycles);
            end else begin
                mem_ready = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [58:0] others;
        reset = 1'b1; instr = '0; mem_ready = 1'b0; alu_flag = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read_held: got %b want 0", mem_read); end
        n_cmp++; if (pc !== PC_RST) begin n_bad++; $display("FAIL reset_pc_held: got %h want %h", pc, PC_RST); end
        reset = 1'b0;
        #1;
        others = {mem_write, mem_addr_sel, reg_write, b_sel_imm, wb_sel_mem, halted, illegal,
                  alu_op, rd, ra, rb, imm};
        n_cmp++; if (pc !== PC_RST) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, PC_RST); end
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL reset_mem_read_rise: got %b want 1", mem_read); end
        n_cmp++; if (others !== '0) begin n_bad++; $display("FAIL reset_others: got %h want 0", others); end
        // Without mem_ready FETCH must hold its strobe
        @(posedge clock); #1;
        n_cmp++; if (mem_read !== 1'b1 || pc !== PC_RST) begin n_bad++; $display("FAIL fetch_hold: mem_read %b pc %h want 1 %h", mem_read, pc, PC_RST); end
    endtask

    task automatic test_alu();
        rec_t e, o;
        e = blank_rec();
        e.cycles = 4; e.pc = 32'h101; e.writes = 1; e.wr_cycle = 4; e.rd = 4'd3;
        e.alu_op = 8'h20; e.ra = 4'd1; e.rb = 4'd2; e.bsel = 1'b0; e.wb_mem = 1'b0;
        sb.push_back(e);
        run_instr(32'h2031_2000, 1, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if (o.cycles !== e.cycles) begin n_bad++; $display("FAIL alu_cycles: got %0d want %0d", o.cycles, e.cycles); end
        n_cmp++; if (o.alu_op !== e.alu_op) begin n_bad++; $display("FAIL alu_op: got %h want %h", o.alu_op, e.alu_op); end
        n_cmp++; if (o.ra !== e.ra || o.rb !== e.rb) begin n_bad++; $display("FAIL alu_ra_rb: got %h %h want %h %h", o.ra, o.rb, e.ra, e.rb); end
        n_cmp++; if (o.bsel !== e.bsel) begin n_bad++; $display("FAIL alu_bsel: got %b want %b", o.bsel, e.bsel); end
        n_cmp++; if (o.writes !== e.writes || o.wr_cycle !== e.wr_cycle) begin n_bad++; $display("FAIL alu_write: got %0d@%0d want %0d@%0d", o.writes, o.wr_cycle, e.writes, e.wr_cycle); end
        n_cmp++; if (o.rd !== e.rd || o.wb_mem !== e.wb_mem) begin n_bad++; $display("FAIL alu_rd_wb: got %h %b want %h %b", o.rd, o.wb_mem, e.rd, e.wb_mem); end
        n_cmp++; if (o.pc !== e.pc) begin n_bad++; $display("FAIL alu_pc: got %h want %h", o.pc, e.pc); end
    endtask

    task automatic test_load();
        rec_t e, o;
        e = blank_rec();
        e.cycles = 7; e.pc = 32'h102; e.writes = 1; e.wr_cycle = 7; e.rd = 4'd4; e.wb_mem = 1'b1;
        e.mem_rd = 3; e.mem_wr = 0; e.alu_op = 8'h20; e.ra = 4'd5; e.imm = 32'hFFFF_FFFC; e.bsel = 1'b1;
        sb.push_back(e);
        run_instr(32'h0145_0FFC, 3, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if (o.imm !== e.imm || o.bsel !== e.bsel) begin n_bad++; $display("FAIL load_imm_bsel: got %h %b want %h %b", o.imm, o.bsel, e.imm, e.bsel); end
        n_cmp++; if (o.alu_op !== e.alu_op || o.ra !== e.ra) begin n_bad++; $display("FAIL load_alu_ra: got %h %h want %h %h", o.alu_op, o.ra, e.alu_op, e.ra); end
        n_cmp++; if (o.mem_rd !== e.mem_rd || o.mem_wr !== e.mem_wr) begin n_bad++; $display("FAIL load_mem_cycles: got rd %0d wr %0d want %0d %0d", o.mem_rd, o.mem_wr, e.mem_rd, e.mem_wr); end
        n_cmp++; if (o.writes !== e.writes || o.wb_mem !== e.wb_mem || o.rd !== e.rd) begin n_bad++; $display("FAIL load_wb: got %0d %b %h want %0d %b %h", o.writes, o.wb_mem, o.rd, e.writes, e.wb_mem, e.rd); end
        n_cmp++; if (o.cycles !== e.cycles || o.pc !== e.pc) begin n_bad++; $display("FAIL load_done: got %0d %h want %0d %h", o.cycles, o.pc, e.cycles, e.pc); end
    endtask

    task automatic test_store();
        rec_t e, o;
        e = blank_rec();
        e.cycles = 4; e.pc = 32'h103; e.mem_wr = 1; e.mem_rd = 0; e.writes = 0;
        e.alu_op = 8'h20; e.rb = 4'd2; e.bsel = 1'b1;
        sb.push_back(e);
        run_instr(32'h0201_2000, 1, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if (o.mem_wr !== e.mem_wr || o.mem_rd !== e.mem_rd || o.writes !== e.writes) begin n_bad++; $display("FAIL store_strobes: got wr %0d rd %0d regw %0d want %0d %0d %0d", o.mem_wr, o.mem_rd, o.writes, e.mem_wr, e.mem_rd, e.writes); end
        n_cmp++; if (o.alu_op !== e.alu_op || o.rb !== e.rb || o.bsel !== e.bsel) begin n_bad++; $display("FAIL store_fields: got %h %h %b want %h %h %b", o.alu_op, o.rb, o.bsel, e.alu_op, e.rb, e.bsel); end
        n_cmp++; if (o.cycles !== e.cycles || o.pc !== e.pc) begin n_bad++; $display("FAIL store_done: got %0d %h want %0d %h", o.cycles, o.pc, e.cycles, e.pc); end
    endtask

    // Steps: JMP to 0x10, BRF -2 taken, JMP back to 0x10, BRF -2 not taken
    task automatic test_branch();
        logic [31:0] words [4] = '{32'h1000_0F0D, 32'h1100_0FFE, 32'h1000_0002, 32'h1100_0FFE};
        logic        flags [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] pcs   [4] = '{32'h10, 32'h0E, 32'h10, 32'h11};
        rec_t e, o;
        for (int i = 0; i < 4; i++) begin
            e = blank_rec();
            e.cycles = 3; e.pc = pcs[i];
            sb.push_back(e);
            run_instr(words[i], 1, flags[i], o);
            e = sb.pop_front();
            n_cmp++; if (o.pc !== e.pc) begin n_bad++; $display("FAIL branch_pc[%0d]: got %h want %h", i, o.pc, e.pc); end
            n_cmp++; if (o.cycles !== e.cycles || o.writes !== 0) begin n_bad++; $display("FAIL branch_cycles[%0d]: got %0d writes %0d want %0d 0", i, o.cycles, o.writes, e.cycles); end
        end
    endtask

    task automatic test_jmp_wrap();
        logic [31:0] words [2] = '{32'h1000_0FEE, 32'h1000_0001};
        logic [31:0] pcs   [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
        rec_t e, o;
        for (int i = 0; i < 2; i++) begin
            e = blank_rec();
            e.pc = pcs[i];
            sb.push_back(e);
            run_instr(words[i], 1, 1'b0, o);
            e = sb.pop_front();
            n_cmp++; if (o.pc !== e.pc) begin n_bad++; $display("FAIL jmp_wrap_pc[%0d]: got %h want %h", i, o.pc, e.pc); end
        end
    endtask

    task automatic test_illegal_nop();
        logic [31:0] words [2] = '{32'h7E12_3456, 32'h0000_0000};
        int          ill   [2] = '{1, 0};
        logic [31:0] pcs   [2] = '{32'h1, 32'h2};
        rec_t e, o;
        for (int i = 0; i < 2; i++) begin
            e = blank_rec();
            e.cycles = 3; e.pc = pcs[i]; e.illegal_cnt = ill[i];
            sb.push_back(e);
            run_instr(words[i], 1, 1'b0, o);
            e = sb.pop_front();
            n_cmp++; if (o.illegal_cnt !== e.illegal_cnt) begin n_bad++; $display("FAIL illegal_pulse[%0d]: got %0d want %0d", i, o.illegal_cnt, e.illegal_cnt); end
            n_cmp++; if (o.pc !== e.pc || o.cycles !== e.cycles) begin n_bad++; $display("FAIL illegal_pc[%0d]: got %h %0d want %h %0d", i, o.pc, o.cycles, e.pc, e.cycles); end
            n_cmp++; if (o.writes !== 0 || o.mem_rd !== 0 || o.mem_wr !== 0) begin n_bad++; $display("FAIL illegal_strobes[%0d]: got %0d %0d %0d want 0 0 0", i, o.writes, o.mem_rd, o.mem_wr); end
        end
    endtask

    task automatic test_halt();
        rec_t e, o;
        int strobes, not_halted;
        e = blank_rec();
        e.cycles = 3; e.pc = 32'h2;
        sb.push_back(e);
        run_instr(32'hFF00_0000, 1, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if (o.cycles !== e.cycles || halted !== 1'b1) begin n_bad++; $display("FAIL halt_entry: got %0d halted %b want %0d 1", o.cycles, halted, e.cycles); end
        strobes = 0; not_halted = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'b1;
            alu_flag  = i[0];
            @(posedge clock); #1;
            if (mem_read || mem_write || reg_write || mem_addr_sel || illegal) strobes++;
            if (!halted) not_halted++;
        end
        n_cmp++; if (strobes !== 0 || not_halted !== 0) begin n_bad++; $display("FAIL halt_absorb: strobes %0d unhalted %0d want 0 0", strobes, not_halted); end
        n_cmp++; if (pc !== e.pc) begin n_bad++; $display("FAIL halt_pc: got %h want %h", pc, e.pc); end
    endtask

    task automatic test_store_reset();
        logic seen;
        reset = 1'b1;
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_reset_exit: got %b want 0", halted); end
        @(posedge clock); #1;
        reset = 1'b0;
        instr = 32'h0201_2000;
        mem_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            mem_ready = 1'b0;
            if (mem_write) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL store_mem_write_timeout: got %b want 1", seen); end
        @(posedge clock); #1;
        n_cmp++; if (mem_write !== 1'b1 || pc !== PC_RST) begin n_bad++; $display("FAIL store_wait_hold: got %b %h want 1 %h", mem_write, pc, PC_RST); end
        // Mid-cycle, well away from any rising edge
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_write !== 1'b0 || mem_addr_sel !== 1'b0) begin n_bad++; $display("FAIL store_async_drop: got %b %b want 0 0", mem_write, mem_addr_sel); end
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (pc !== PC_RST || mem_read !== 1'b1 || reg_write !== 1'b0) begin n_bad++; $display("FAIL store_after_reset: got %h %b %b want %h 1 0", pc, mem_read, reg_write, PC_RST); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jmp_wrap();
        test_illegal_nop();
        test_halt();
        test_store_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
